// File: rtl/snn_pkg.sv
// Shared types and helpers for the SNN layer engine: FSM states, width helper,
// and the shift/clamp/offset mapping from accumulator to activation LUT address.
package snn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_ACT,
        S_WAIT,
        S_WRITE,
        S_FIN
    } state_t;

    // Address width for a depth of n entries, never narrower than one bit.
    function automatic int clog2w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Shift, clamp to the signed aw-bit range, then offset so the most negative value maps to 0.
    function automatic logic [31:0] sat_offset(input logic signed [63:0] acc,
                                               input int shift, input int aw);
        logic signed [63:0] pre;
        logic signed [63:0] lim;
        pre = acc >>> shift;
        lim = 64'sd1 <<< (aw - 1);
        if (pre > lim - 64'sd1)
            pre = lim - 64'sd1;
        else if (pre < -lim)
            pre = -lim;
        pre = pre + lim;
        return pre[31:0];
    endfunction

endpackage

// File: rtl/snn_mac.sv
// Per-neuron multiply-accumulate: selects the input term, accumulates it, and
// presents the saturated, offset LUT address of the running sum plus the current term.
module snn_mac
    import snn_pkg::*;
#(
    parameter int IN_W       = 1,
    parameter int W_W        = 8,
    parameter int ACC_W      = 12,
    parameter int ACT_AW     = 11,
    parameter int FRAC_SHIFT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [IN_W-1:0]   q_in,
    input  logic [W_W-1:0]    q_w,
    output logic [ACT_AW-1:0] sat_addr
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] acc_nxt;
    logic signed [ACC_W-1:0] w_ext;

    assign w_ext = ACC_W'($signed(q_w));

    generate
        if (IN_W == 1) begin : g_gate
            assign term = q_in[0] ? w_ext : '0;
        end else begin : g_mult
            // Operands widened first so the product is formed at full accumulator width.
            logic signed [ACC_W-1:0] a_ext;
            assign a_ext = ACC_W'($signed({1'b0, q_in}));
            assign term  = a_ext * w_ext;
        end
    endgenerate

    assign acc_nxt  = acc + term;
    assign sat_addr = ACT_AW'(sat_offset(64'(acc_nxt), FRAC_SHIFT, ACT_AW));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc_nxt;
    end

endmodule

// File: rtl/snn_layer_engine.sv
// Fully-connected SNN layer sequencer: streams inputs and weights from sync RAMs,
// accumulates per neuron, maps through an activation LUT, writes results and tracks argmax.
module snn_layer_engine
    import snn_pkg::*;
#(
    parameter int N_IN       = 784,
    parameter int N_OUT      = 10,
    parameter int IN_W       = 1,
    parameter int W_W        = 8,
    parameter int ACT_AW     = 11,
    parameter int OUT_W      = 8,
    parameter int FRAC_SHIFT = 0,
    localparam int AI_W      = clog2w(N_IN),
    localparam int AW_W      = clog2w(N_IN * N_OUT),
    localparam int AO_W      = clog2w(N_OUT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              done,
    output logic [AI_W-1:0]   addr_in,
    input  logic [IN_W-1:0]   q_in,
    output logic [AW_W-1:0]   addr_w,
    input  logic [W_W-1:0]    q_w,
    output logic [ACT_AW-1:0] addr_act,
    input  logic [OUT_W-1:0]  q_act,
    output logic [AO_W-1:0]   addr_out,
    output logic [OUT_W-1:0]  d_out,
    output logic              we_out,
    output logic [AO_W-1:0]   max_idx
);

    localparam int ACC_W = W_W + IN_W + 1 + clog2w(N_IN);

    state_t            state;
    logic [AO_W-1:0]   n_cnt;
    logic [OUT_W-1:0]  maxval;
    logic [ACT_AW-1:0] sat_addr;
    logic              mac_clr;
    logic              mac_en;

    // addr_in doubles as the input index i; data for it arrives one cycle later.
    assign mac_clr = ((state == S_IDLE) && start) || (state == S_WRITE);
    assign mac_en  = ((state == S_MAC) && (addr_in != '0)) || (state == S_DRAIN);

    snn_mac #(
        .IN_W      (IN_W),
        .W_W       (W_W),
        .ACC_W     (ACC_W),
        .ACT_AW    (ACT_AW),
        .FRAC_SHIFT(FRAC_SHIFT)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (mac_clr),
        .en      (mac_en),
        .q_in    (q_in),
        .q_w     (q_w),
        .sat_addr(sat_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            done     <= 1'b0;
            we_out   <= 1'b0;
            max_idx  <= '0;
            maxval   <= '0;
            n_cnt    <= '0;
            addr_in  <= '0;
            addr_w   <= '0;
            addr_act <= '0;
            addr_out <= '0;
            d_out    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_MAC;
                        done    <= 1'b0;
                        n_cnt   <= '0;
                        addr_in <= '0;
                        addr_w  <= '0;
                        maxval  <= '0;
                    end
                end
                S_MAC: begin
                    if (addr_in == AI_W'(N_IN - 1)) begin
                        state <= S_DRAIN;
                    end else begin
                        addr_in <= addr_in + 1'b1;
                        addr_w  <= addr_w + 1'b1;
                    end
                end
                S_DRAIN: begin
                    addr_act <= sat_addr;
                    state    <= S_ACT;
                end
                S_ACT: state <= S_WAIT;
                S_WAIT: begin
                    we_out   <= 1'b1;
                    addr_out <= n_cnt;
                    d_out    <= q_act;
                    state    <= S_WRITE;
                end
                S_WRITE: begin
                    we_out <= 1'b0;
                    // Strict compare: ties keep the lowest neuron index.
                    if ((n_cnt == '0) || (d_out > maxval)) begin
                        maxval  <= d_out;
                        max_idx <= n_cnt;
                    end
                    if (n_cnt == AO_W'(N_OUT - 1)) begin
                        state <= S_FIN;
                    end else begin
                        n_cnt   <= n_cnt + 1'b1;
                        addr_in <= '0;
                        addr_w  <= addr_w + 1'b1;
                        state   <= S_MAC;
                    end
                end
                S_FIN: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_layer_engine.sv
// Bench for snn_layer_engine: gate-mode and multiply-mode instances, sync RAM models,
// identity activation LUT, and an arithmetic reference model of each layer output.
module tb_snn_layer_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start_a = 1'b0, start_b = 1'b0;
    logic       done_a, done_b, we_out_a, we_out_b;
    logic [1:0] addr_in_a, addr_in_b, addr_out_a, addr_out_b, max_idx_a, max_idx_b;
    logic [3:0] addr_w_a, addr_w_b;
    logic [7:0] addr_act_a, addr_act_b, q_act_a, q_act_b, d_out_a, d_out_b;
    logic [7:0] q_w_a, q_w_b, q_in_b;
    logic [0:0] q_in_a;

    logic [0:0] in_a [4];
    logic [7:0] in_b [4];
    logic [7:0] w_a  [16];
    logic [7:0] w_b  [16];

    snn_layer_engine #(.N_IN(4), .N_OUT(3), .IN_W(1), .W_W(8), .ACT_AW(8), .OUT_W(8), .FRAC_SHIFT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .done(done_a),
        .addr_in(addr_in_a), .q_in(q_in_a), .addr_w(addr_w_a), .q_w(q_w_a),
        .addr_act(addr_act_a), .q_act(q_act_a), .addr_out(addr_out_a), .d_out(d_out_a),
        .we_out(we_out_a), .max_idx(max_idx_a));

    snn_layer_engine #(.N_IN(4), .N_OUT(3), .IN_W(8), .W_W(8), .ACT_AW(8), .OUT_W(8), .FRAC_SHIFT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .done(done_b),
        .addr_in(addr_in_b), .q_in(q_in_b), .addr_w(addr_w_b), .q_w(q_w_b),
        .addr_act(addr_act_b), .q_act(q_act_b), .addr_out(addr_out_b), .d_out(d_out_b),
        .we_out(we_out_b), .max_idx(max_idx_b));

    // One-cycle synchronous RAMs; the LUT returns its own address.
    always @(posedge clk) begin
        q_in_a  <= in_a[addr_in_a];
        q_w_a   <= w_a[addr_w_a];
        q_act_a <= addr_act_a;
        q_in_b  <= in_b[addr_in_b];
        q_w_b   <= w_b[addr_w_b];
        q_act_b <= addr_act_b;
    end

    int n_chk = 0, n_pass = 0;
    int cyc, nwr;
    logic [7:0] got [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    endtask

    // Reference: dot product, clamp to signed 8-bit, offset by 128 (identity LUT).
    function automatic int model_act(input bit ub, input int n);
        int s = 0;
        for (int i = 0; i < 4; i++) begin
            if (ub) s += int'(in_b[i]) * int'($signed(w_b[n*4+i]));
            else if (in_a[i] == 1'b1) s += int'($signed(w_a[n*4+i]));
        end
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s + 128;
    endfunction

    function automatic int model_argmax(input bit ub);
        int best = 0;
        for (int n = 1; n < 3; n++)
            if (model_act(ub, n) > model_act(ub, best)) best = n;
        return best;
    endfunction

    // Pulse start (edge k), then follow up to 60 edges recording writes until done.
    task automatic run(input bit ub, input int restart_at, input bit hold);
        cyc = 0;
        nwr = 0;
        for (int j = 0; j < 4; j++) got[j] = 8'hxx;
        if (ub) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 60; c++) begin
            if (ub) start_b = hold || (c == restart_at);
            else    start_a = hold || (c == restart_at);
            @(posedge clk); #1;
            if (ub ? we_out_b : we_out_a) begin
                got[ub ? addr_out_b : addr_out_a] = ub ? d_out_b : d_out_a;
                nwr++;
            end
            if (ub ? done_b : done_a) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic verify(input bit ub);
        check(ub ? "b.done_cycle" : "a.done_cycle", cyc, 25);
        check(ub ? "b.writes" : "a.writes", nwr, 3);
        for (int n = 0; n < 3; n++)
            check(ub ? "b.d_out" : "a.d_out", 32'(got[n]), model_act(ub, n));
        check(ub ? "b.max_idx" : "a.max_idx", 32'(ub ? max_idx_b : max_idx_a), model_argmax(ub));
    endtask

    initial begin
        for (int j = 0; j < 16; j++) begin w_a[j] = 8'd0; w_b[j] = 8'd0; end
        for (int j = 0; j < 4; j++) begin in_a[j] = 1'b0; in_b[j] = 8'd0; end
        repeat (2) @(posedge clk);
        #1;
        check("rst.done", 32'(done_a), 0);
        check("rst.we_out", 32'(we_out_a), 0);
        check("rst.max_idx", 32'(max_idx_a), 0);
        check("rst.addr_w", 32'(addr_w_a), 0);
        check("rst.addr_act", 32'(addr_act_b), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All inputs set, all weights +1: three writes of 132, tie resolves to index 0.
        for (int j = 0; j < 4; j++) in_a[j] = 1'b1;
        for (int j = 0; j < 12; j++) w_a[j] = 8'd1;
        run(1'b0, 0, 1'b0);
        verify(1'b0);
        check("t1.d_out0", 32'(got[0]), 132);
        check("t1.max_idx", 32'(max_idx_a), 0);
        repeat (5) @(posedge clk);
        #1;
        check("t1.done_held", 32'(done_a), 1);

        // Mixed weights over inputs 1010.
        in_a[0] = 1'b1; in_a[1] = 1'b0; in_a[2] = 1'b1; in_a[3] = 1'b0;
        for (int j = 0; j < 4; j++) begin w_a[j] = 8'hFF; w_a[4+j] = 8'd2; w_a[8+j] = 8'd1; end
        run(1'b0, 0, 1'b0);
        verify(1'b0);
        check("t2.d_out1", 32'(got[1]), 132);
        check("t2.max_idx", 32'(max_idx_a), 1);

        // Multiply mode saturation in both directions.
        for (int j = 0; j < 4; j++) in_b[j] = 8'd255;
        for (int j = 0; j < 12; j++) w_b[j] = 8'd127;
        run(1'b1, 0, 1'b0);
        verify(1'b1);
        check("t3.clamp_hi", 32'(got[2]), 255);
        for (int j = 0; j < 4; j++) begin w_b[j] = 8'h80; w_b[4+j] = 8'd127; w_b[8+j] = 8'h80; end
        run(1'b1, 0, 1'b0);
        verify(1'b1);
        check("t3.clamp_lo", 32'(got[0]), 0);

        // Start while busy is ignored.
        run(1'b0, 10, 1'b0);
        verify(1'b0);

        // Start held high: done lasts one cycle, then the next run is accepted.
        run(1'b0, 0, 1'b1);
        verify(1'b0);
        @(posedge clk); #1;
        check("hold.done_pulse", 32'(done_a), 0);
        start_a = 1'b0;

        // Asynchronous reset in the middle of the second neuron's write.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("t5.we_before", 32'(we_out_a), 1);
        rst_n = 1'b0;
        #1;
        check("t5.we_reset", 32'(we_out_a), 0);
        check("t5.done_reset", 32'(done_a), 0);
        check("t5.max_idx_reset", 32'(max_idx_a), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(1'b0, 0, 1'b0);
        verify(1'b0);

        // Randomized layers on both instances.
        for (int t = 0; t < 6; t++) begin
            for (int j = 0; j < 4; j++) begin
                in_a[j] = 1'($urandom_range(0, 1));
                in_b[j] = 8'($urandom_range(0, 3));
            end
            for (int j = 0; j < 12; j++) begin
                w_a[j] = 8'($urandom_range(0, 255));
                w_b[j] = 8'($urandom_range(0, 255));
            end
            run(1'b0, 0, 1'b0);
            verify(1'b0);
            run(1'b1, 0, 1'b0);
            verify(1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
